fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the decode-side field splitter, which consumes `instruction_out` and `pc_plus4_out`.
- Holds the PC and a word-addressed instruction memory, with a debug-unit load port.
- Selects the next PC from sequential, branch, jump or jump-register sources.
- Registers the fetched word into the IF/ID latch, with stall, flush and HALT handling.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_stage_instruction_memory.sv | 30 +++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, pc_src encodings and instruction constants
// for the instruction-fetch stage and the decode-side field splitter.
// No ports; imported with "import fetch_stage_pkg::*".
package fetch_stage_pkg;

  localparam int NB_DATA      = 32;  // instruction and data width
  localparam int NB_PC        = 32;  // program counter width
  localparam int NB_ADDR      = 8;   // instruction memory word-address width
  localparam int NB_DIRECTION = 26;  // J-type direction field width
  localparam int NB_SEL       = 2;   // pc_src selector width

  typedef enum logic [NB_SEL-1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_JREG   = 2'd3
  } pc_src_e;

  localparam logic [5:0]         OP_HALT  = 6'b111111;
  localparam logic [NB_DATA-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [NB_PC-1:0]   PC_STEP  = 32'd4;

  // True when the opcode field of a fetched word is HALT.
  function automatic logic is_halt(input logic [NB_DATA-1:0] word);
    return (word[NB_DATA-1 -: 6] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's control inputs, debug load port
// and IF/ID outputs.
//   master : pipeline control / debug unit side (drives controls, reads IF/ID)
//   slave  : fetch_stage side (reads controls, drives IF/ID and debug status)
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                    enable;
  logic                    stall;
  logic [NB_SEL-1:0]       pc_src;
  logic [NB_PC-1:0]        branch_target;
  logic [NB_DIRECTION-1:0] jump_direction;
  logic [NB_PC-1:0]        jump_register;
  logic                    load_en;
  logic [NB_ADDR-1:0]      load_addr;
  logic [NB_DATA-1:0]      load_data;
  logic [NB_DATA-1:0]      instruction_out;
  logic [NB_PC-1:0]        pc_plus4_out;
  logic                    valid_out;
  logic [NB_PC-1:0]        pc;
  logic                    halted;

  modport master (
    output enable, stall, pc_src, branch_target, jump_direction, jump_register,
           load_en, load_addr, load_data,
    input  instruction_out, pc_plus4_out, valid_out, pc, halted
  );

  modport slave (
    input  enable, stall, pc_src, branch_target, jump_direction, jump_register,
           load_en, load_addr, load_data,
    output instruction_out, pc_plus4_out, valid_out, pc, halted
  );

endinterface

// File: rtl/fetch_stage_instruction_memory.sv
// instruction_memory: word-addressed instruction store.
//   clock            : write clock
//   wr_en/addr/data  : synchronous write port (debug load)
//   rd_addr/rd_data  : combinational read port (fetch); a read of the address
//                      being written in the same cycle returns the old word
// Contents are not reset.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem_r [2**NB_ADDR];

  // Debug-unit write port.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline. Holds the PC, the
// instruction memory and the IF/ID latch.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (memory contents retained)
//   bus   : control inputs, debug load port and IF/ID outputs (slave side)
// Per-cycle priority: reset, enable=0 hold, redirect, halted, stall, normal.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  logic [NB_PC-1:0]   pc_r;
  logic [NB_DATA-1:0] instr_r;
  logic [NB_PC-1:0]   pc_plus4_r;
  logic               valid_r;
  logic               halted_r;

  logic [NB_DATA-1:0] fetch_word_s;
  logic [NB_PC-1:0]   pc_inc_s;
  logic [NB_PC-1:0]   next_pc_s;
  logic               redirect_s;

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .clock   (clock),
    .wr_en   (bus.load_en),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_addr (pc_r[NB_ADDR+1:2]),
    .rd_data (fetch_word_s)
  );

  assign pc_inc_s   = pc_r + PC_STEP;
  assign redirect_s = (pc_src_e'(bus.pc_src) != PC_SRC_SEQ);

  // Next-PC mux; the jump region comes from the registered IF/ID PC+4.
  always_comb begin
    next_pc_s = pc_inc_s;
    case (pc_src_e'(bus.pc_src))
      PC_SRC_SEQ:    next_pc_s = pc_inc_s;
      PC_SRC_BRANCH: next_pc_s = bus.branch_target;
      PC_SRC_JUMP:   next_pc_s = {pc_plus4_r[NB_PC-1 -: 4], bus.jump_direction, 2'b00};
      PC_SRC_JREG:   next_pc_s = bus.jump_register;
      default:       next_pc_s = pc_inc_s;
    endcase
  end

  // PC and IF/ID latch update. A redirect beats stall and halt because it
  // comes from an older instruction that squashes whatever is being fetched.
  // pc_plus4 is only refreshed on a real fetch, so jumps keep a valid region.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= '0;
      instr_r    <= NOP_WORD;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else if (!bus.enable) begin
      pc_r       <= pc_r;
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
      halted_r   <= halted_r;
    end else if (redirect_s) begin
      pc_r     <= next_pc_s;
      instr_r  <= NOP_WORD;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else if (halted_r) begin
      instr_r <= NOP_WORD;
      valid_r <= 1'b0;
    end else if (bus.stall) begin
      pc_r    <= pc_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end else begin
      instr_r    <= fetch_word_s;
      pc_plus4_r <= pc_inc_s;
      valid_r    <= 1'b1;
      // PC parks on the HALT word so a later redirect or reset resumes cleanly.
      if (is_halt(fetch_word_s)) begin
        halted_r <= 1'b1;
      end else begin
        pc_r <= pc_inc_s;
      end
    end
  end

  assign bus.instruction_out = instr_r;
  assign bus.pc_plus4_out    = pc_plus4_r;
  assign bus.valid_out       = valid_r;
  assign bus.pc              = pc_r;
  assign bus.halted          = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed stimulus for fetch_stage, checked
// every cycle against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic clock;
  logic reset;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_halted;
  bit          m_p4_known;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch rules, using the currently driven inputs.
  task automatic model_edge();
    int unsigned idx;
    logic [31:0] word, target;
    idx  = (m_pc / 4) % 256;
    word = m_mem[idx];
    if (reset) begin
      m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_halted = 0; m_p4_known = 1;
    end else if (!bus.enable) begin
      // nothing moves
    end else if (bus.pc_src != 2'd0) begin
      if (bus.pc_src == 2'd1)      target = bus.branch_target;
      else if (bus.pc_src == 2'd2) target = (m_p4 & 32'hF000_0000) + bus.jump_direction * 4;
      else                         target = bus.jump_register;
      m_pc = target; m_instr = 0; m_valid = 0; m_halted = 0; m_p4_known = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0; m_p4_known = 0;
    end else if (bus.stall) begin
      // hold
    end else begin
      m_instr = word; m_p4 = m_pc + 4; m_valid = 1; m_p4_known = 1;
      if ((word >> 26) == 32'd63) m_halted = 1;
      else m_pc = m_pc + 4;
    end
    if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_eq("pc", bus.pc, m_pc);
    check_eq("instruction_out", bus.instruction_out, m_instr);
    check_eq("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
    check_eq("halted", {31'd0, bus.halted}, {31'd0, m_halted});
    if (m_p4_known) check_eq("pc_plus4_out", bus.pc_plus4_out, m_p4);
  endtask

  task automatic idle_inputs();
    bus.enable = 1'b1; bus.stall = 1'b0; bus.pc_src = 2'd0;
    bus.branch_target = 32'd0; bus.jump_direction = 26'd0; bus.jump_register = 32'd0;
    bus.load_en = 1'b0; bus.load_addr = 8'd0; bus.load_data = 32'd0;
  endtask

  logic [31:0] prog [4];
  logic [31:0] w;
  logic [31:0] saved_pc;

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'hFC00_0000;
    idle_inputs();
    reset = 1'b1;
    m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_halted = 0; m_p4_known = 1;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    @(posedge clock); #1;

    // Preload the whole memory under reset (writes ignore reset).
    for (int i = 0; i < 256; i++) begin
      if (i < 4) w = prog[i];
      else begin
        w = $urandom;
        if ((w >> 26) == 32'd63) w = w ^ 32'h0400_0000;
      end
      bus.load_en = 1'b1; bus.load_addr = i[7:0]; bus.load_data = w;
      step();
    end
    bus.load_en = 1'b0;
    step();

    // Program run up to HALT, then idle while halted.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("halt_pc", bus.pc, 32'h0000_000C);

    // Redirect while halted cancels the halt.
    bus.pc_src = 2'd1; bus.branch_target = 32'h20; step();
    bus.pc_src = 2'd0; step(); step();

    // Stall two cycles at pc=8.
    bus.pc_src = 2'd1; bus.branch_target = 32'h8; step();
    bus.pc_src = 2'd0; bus.stall = 1'b1; step(); step();
    bus.stall = 1'b0; step();
    check_eq("stall_resume_pc", bus.pc, 32'h0000_000C);

    // Branch together with stall: redirect wins, then fetch mem[16].
    bus.pc_src = 2'd1; bus.branch_target = 32'h40; bus.stall = 1'b1; step();
    bus.pc_src = 2'd0; bus.stall = 1'b0; step();

    // Jump with pc_plus4_out=8, then jump-register to the last word and wrap.
    bus.pc_src = 2'd1; bus.branch_target = 32'h4; step();
    bus.pc_src = 2'd0; step();
    bus.pc_src = 2'd2; bus.jump_direction = 26'h10; step();
    check_eq("jump_pc", bus.pc, 32'h0000_0040);
    bus.pc_src = 2'd3; bus.jump_register = 32'h3FC; step();
    bus.pc_src = 2'd0; step(); step();

    // enable=0 freezes everything.
    bus.enable = 1'b0; bus.stall = 1'b1; step(); bus.stall = 1'b0; step();
    bus.enable = 1'b1;

    // Write the word at pc while it is fetched: old word now, new word later.
    saved_pc = bus.pc;
    bus.load_en = 1'b1; bus.load_addr = saved_pc[9:2]; bus.load_data = 32'h1234_5678; step();
    bus.load_en = 1'b0;
    bus.pc_src = 2'd1; bus.branch_target = saved_pc; step();
    bus.pc_src = 2'd0; step();

    // Mid-run reset, then restart from 0 with memory retained.
    reset = 1'b1; step();
    reset = 1'b0; step(); step();

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      reset              = ($urandom_range(0, 99) == 0);
      bus.enable         = ($urandom_range(0, 9) != 0);
      bus.stall          = ($urandom_range(0, 4) == 0);
      bus.pc_src         = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.branch_target  = $urandom & 32'hFFFF_FFFC;
      bus.jump_direction = 26'($urandom);
      bus.jump_register  = $urandom & 32'hFFFF_FFFC;
      bus.load_en        = ($urandom_range(0, 9) == 0);
      bus.load_addr      = 8'($urandom);
      bus.load_data      = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
